sha256_msg_controller: RTL and testbench
========================================

SHA256_MSG_CONTROLLER -- requirements
Module: sha256_msg_controller

Interface
REQ-001 SHALL have parameter IV, default 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19, the SHA-256 initial hash loaded at each message start.
REQ-002 SHALL have these ports: clk in 1 (clock); rst in 1 (reset, asynchronous, active-high).
REQ-003 SHALL have s_data in 8 (message byte) and s_valid in 1 (byte valid).
REQ-004 SHALL have s_last in 1 (final byte of message, qualified by s_valid) and s_ready out 1 (byte accepted when s_valid && s_ready).
REQ-005 SHALL have these compression-loop ports: enable out 1 (loop enable) and start out 1 (block start pulse).
REQ-006 SHALL have word_address in 4, req_word in 1, word_data out 32 and word_valid out 1 for word serving.
REQ-007 SHALL have load_done in 1, busy in 1 (monitored only), prev_hash out 256 (chaining value) and hash_ack out 1 (prev_hash valid).
REQ-008 SHALL have hash_out in 256 (chained result) and hash_valid in 1 (result valid).
REQ-009 SHALL have digest out 256 (final message digest) and digest_valid out 1 (digest valid).

Function
REQ-010 SHALL buffer one 512-bit block as 16x32-bit words, byte i of the block at word i/4, bits [31-8*(i%4) -: 8] (big-endian).
REQ-011 SHALL implement FSM states IDLE, FILL, PAD, LEN, ISSUE, SERVE, HASH with 6-bit byte index idx.
REQ-012 SHALL assert s_ready only in IDLE and FILL.
REQ-013 IDLE: on an accepted byte, SHALL load H<=IV, clear digest_valid and the 64-bit bit counter, write the byte at idx 0, and go to FILL with idx=1 (or PAD with idx=1 if s_last).
REQ-014 FILL: each accepted byte SHALL be written at idx, with idx+1 and bitcount+8 (mod 2^64); on s_last go to PAD; else if idx==63 go to ISSUE.
REQ-015 PAD SHALL write one byte per cycle at idx: 0x80 if not yet written for this message, else 0x00, then increment idx.
REQ-016 PAD exit: after writing idx 55 with 0x80 already written, SHALL go to LEN; after writing idx 63, SHALL go to ISSUE with len_pending=1.
REQ-017 LEN SHALL write bitcount MSB-first at idx 56..63, one byte per cycle, then go to ISSUE with final=1.
REQ-018 ISSUE SHALL pulse start=1 for exactly one cycle, then go to SERVE.
REQ-019 enable SHALL be 1 in every state except reset.
REQ-020 SERVE: word_valid SHALL equal req_word combinationally, with word_data=buf[word_address] in the same cycle (zero latency); on load_done go to HASH.
REQ-021 HASH: prev_hash SHALL be H at all times, and hash_ack SHALL be 1 only in HASH.
REQ-022 HASH: on hash_valid, SHALL latch H<=hash_out and set idx=0.
REQ-023 HASH exit on final: SHALL set digest<=hash_out and digest_valid=1, then go to IDLE.
REQ-024 HASH exit on len_pending: SHALL go to PAD.
REQ-025 HASH exit otherwise (last byte was at idx 63 with 0x80 unwritten, or a full data block): SHALL go to FILL, or to PAD if s_last was already seen.
REQ-026 A message ending at idx 63 SHALL produce a second block of 0x80, zeros and length; ending at idx 55..62 SHALL spill the length into a second block; ending at idx <=54 SHALL be a single block.
REQ-027 s_last without a prior byte (zero-length message) SHALL NOT be supported; all messages carry at least 1 byte.
REQ-028 s_valid in states other than IDLE and FILL SHALL be ignored and the byte not consumed.
REQ-029 digest_valid SHALL stay high until the first byte of the next message is accepted.

Reset
REQ-030 On rst SHALL set: state=IDLE, idx=0, H=IV, bitcount=0, all flags 0, start=0, word_valid=0, hash_ack=0, digest=0, digest_valid=0, word_data=0, prev_hash=IV, enable=0 while rst high.
REQ-031 Reset mid-message SHALL discard the buffer contents and resume in IDLE with s_ready=1 on the first cycle after rst deasserts.

Verification
REQ-032 "abc" (3 bytes, last on 'c') -> exactly one start pulse, 16 words served (word 0=0x61626380, word 15=0x00000018), digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-033 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two start pulses, block 2 word 15=0x000001c0, digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-034 55 bytes of 0x61 -> single block with word 13 low byte 0x80 and word 15=0x000001b8; 64 bytes of 0x61 -> two blocks, block 2 word 0=0x80000000 and word 15=0x00000200.
REQ-035 Random s_valid gaps and hash_valid delays of 0-20 cycles -> digest identical to the gap-free run; s_ready=0 throughout PAD, LEN, ISSUE, SERVE and HASH.
REQ-036 rst pulsed during SERVE of "abc", then "abc" resent -> no stale words are served, the loop latches prev_hash=IV, and the correct "abc" digest is produced.

Source files
------------

// File: rtl/sha256_msg_controller.sv
// SHA-256 message front end: packs a byte stream into padded 512-bit blocks,
// serves each block to an external compression loop and chains the hash value.
module sha256_msg_controller #(
    parameter logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic         enable,
    output logic         start,
    input  logic [3:0]   word_address,
    input  logic         req_word,
    output logic [31:0]  word_data,
    output logic         word_valid,
    input  logic         load_done,
    input  logic         busy,
    output logic [255:0] prev_hash,
    output logic         hash_ack,
    input  logic [255:0] hash_out,
    input  logic         hash_valid,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, SERVE, HASH} state_t;

    state_t         state_q;
    logic [5:0]     idx_q;
    logic [31:0]    buf_q [16];
    logic [255:0]   h_q;
    logic [63:0]    bitCount_q;
    logic           padDone_q;
    logic           lenPending_q;
    logic           final_q;
    logic           lastSeen_q;
    logic           start_q;
    logic           hashAck_q;
    logic [255:0]   digest_q;
    logic           digestValid_q;

    logic           accept;
    logic           wrEn;
    logic [7:0]     wrByte;
    logic [7:0]     lenByte;
    logic [31:0]    bufWord_d;
    logic           unusedBusy;

    // busy is only observed by the loop's owner; nothing here depends on it
    assign unusedBusy = busy;

    assign s_ready = (state_q == IDLE) || (state_q == FILL);
    assign accept  = s_valid && s_ready;
    assign lenByte = 8'(bitCount_q >> {~idx_q[2:0], 3'b000});

    always_comb begin
        wrEn   = 1'b0;
        wrByte = 8'h00;
        case (state_q)
            IDLE, FILL: begin
                wrEn   = accept;
                wrByte = s_data;
            end
            PAD: begin
                wrEn   = 1'b1;
                wrByte = padDone_q ? 8'h00 : 8'h80;
            end
            LEN: begin
                wrEn   = 1'b1;
                wrByte = lenByte;
            end
            default: begin
                wrEn   = 1'b0;
                wrByte = 8'h00;
            end
        endcase
    end

    // Big-endian byte lane merge: byte 0 of a word lands in bits [31:24]
    always_comb begin
        bufWord_d = buf_q[idx_q[5:2]];
        case (idx_q[1:0])
            2'd0:    bufWord_d[31:24] = wrByte;
            2'd1:    bufWord_d[23:16] = wrByte;
            2'd2:    bufWord_d[15:8]  = wrByte;
            default: bufWord_d[7:0]   = wrByte;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wrEn) begin
            buf_q[idx_q[5:2]] <= bufWord_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            h_q           <= IV;
            bitCount_q    <= '0;
            padDone_q     <= 1'b0;
            lenPending_q  <= 1'b0;
            final_q       <= 1'b0;
            lastSeen_q    <= 1'b0;
            start_q       <= 1'b0;
            hashAck_q     <= 1'b0;
            digest_q      <= '0;
            digestValid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        h_q           <= IV;
                        digestValid_q <= 1'b0;
                        bitCount_q    <= 64'd8;
                        padDone_q     <= 1'b0;
                        lenPending_q  <= 1'b0;
                        final_q       <= 1'b0;
                        lastSeen_q    <= s_last;
                        idx_q         <= 6'd1;
                        state_q       <= s_last ? PAD : FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        idx_q      <= idx_q + 6'd1;
                        bitCount_q <= bitCount_q + 64'd8;
                        if (s_last) begin
                            lastSeen_q <= 1'b1;
                        end
                        // A full block must go out before padding can start
                        if (idx_q == 6'd63) begin
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end else if (s_last) begin
                            state_q <= PAD;
                        end
                    end
                end
                PAD: begin
                    padDone_q <= 1'b1;
                    idx_q     <= idx_q + 6'd1;
                    if (idx_q == 6'd55) begin
                        state_q <= LEN;
                    end else if (idx_q == 6'd63) begin
                        lenPending_q <= 1'b1;
                        start_q      <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                LEN: begin
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        final_q <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= SERVE;
                end
                SERVE: begin
                    if (load_done) begin
                        hashAck_q <= 1'b1;
                        state_q   <= HASH;
                    end
                end
                HASH: begin
                    if (hash_valid) begin
                        h_q       <= hash_out;
                        idx_q     <= '0;
                        hashAck_q <= 1'b0;
                        if (final_q) begin
                            final_q       <= 1'b0;
                            digest_q      <= hash_out;
                            digestValid_q <= 1'b1;
                            state_q       <= IDLE;
                        end else if (lenPending_q) begin
                            lenPending_q <= 1'b0;
                            state_q      <= PAD;
                        end else begin
                            state_q <= lastSeen_q ? PAD : FILL;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign enable       = ~rst;
    assign start        = start_q;
    assign word_valid   = (state_q == SERVE) && req_word;
    assign word_data    = (state_q == SERVE) ? buf_q[word_address] : 32'h0;
    assign prev_hash    = h_q;
    assign hash_ack     = hashAck_q;
    assign digest       = digest_q;
    assign digest_valid = digestValid_q;

endmodule

// File: tb/tb_sha256_msg_controller.sv
// Bench for sha256_msg_controller: plays the compression loop with a full SHA-256
// round model and compares against a padding-plus-compression reference.
module tb_sha256_msg_controller;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic         enable;
    logic         start;
    logic [3:0]   word_address;
    logic         req_word;
    logic [31:0]  word_data;
    logic         word_valid;
    logic         load_done;
    logic         busy;
    logic [255:0] prev_hash;
    logic         hash_ack;
    logic [255:0] hash_out;
    logic         hash_valid;
    logic [255:0] digest;
    logic         digest_valid;

    logic         loopEnable = 1'b0;
    logic         msgDone = 1'b0;
    int           hashDelayMax = 0;
    logic         mReq = 1'b0;
    logic [3:0]   mAddr = 4'd0;
    logic         lReq;
    logic [3:0]   lAddr;
    logic         loopBusy;

    logic [31:0]  servedWords[$];
    logic [255:0] seenPrev[$];
    int           badValid;
    int           loopTimeouts;
    int           startCount = 0;
    int           readyViol = 0;

    logic [511:0] refBlocks[$];
    logic [255:0] refChain[$];
    logic [255:0] refDigest;

    int           testsRun = 0;
    int           failCount = 0;

    always #5 clk = ~clk;

    assign req_word     = loopEnable ? lReq : mReq;
    assign word_address = loopEnable ? lAddr : mAddr;
    assign busy         = loopBusy;

    sha256_msg_controller #(.IV(IV)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .enable(enable), .start(start),
        .word_address(word_address), .req_word(req_word), .word_data(word_data), .word_valid(word_valid),
        .load_done(load_done), .busy(busy), .prev_hash(prev_hash), .hash_ack(hash_ack),
        .hash_out(hash_out), .hash_valid(hash_valid),
        .digest(digest), .digest_valid(digest_valid)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression including the feed-forward add
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
    endfunction

    // Standard SHA-256 padding of the whole message, then block-by-block chaining
    function automatic void buildRef(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [255:0] hv;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        refBlocks.delete();
        refChain.delete();
        hv = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk = {blk[503:0], p[64*bi + i]};
            refBlocks.push_back(blk);
            refChain.push_back(hv);
            hv = compress(hv, blk);
        end
        refDigest = hv;
    endfunction

    task automatic checkVal(input string name, input logic [511:0] act, input logic [511:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compression-loop stand-in: fetch 16 words, ack, wait a random delay, return chained hash
    task automatic serveBlock();
        logic [511:0] blk;
        int n;
        blk = '0;
        loopBusy = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 16; w++) begin
            lAddr = 4'(w);
            lReq  = 1'b1;
            #1;
            if (word_valid !== 1'b1) badValid++;
            servedWords.push_back(word_data);
            blk = {blk[479:0], word_data};
            @(posedge clk); #1;
        end
        lReq = 1'b0;
        load_done = 1'b1;
        @(posedge clk); #1;
        load_done = 1'b0;
        n = 0;
        while (hash_ack !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (hash_ack !== 1'b1) begin
            loopTimeouts++;
            loopBusy = 1'b0;
            return;
        end
        seenPrev.push_back(prev_hash);
        repeat ($urandom_range(0, hashDelayMax)) begin
            @(posedge clk); #1;
        end
        hash_out   = compress(prev_hash, blk);
        hash_valid = 1'b1;
        @(posedge clk); #1;
        hash_valid = 1'b0;
        loopBusy   = 1'b0;
    endtask

    initial begin : compressionLoop
        lReq = 1'b0; lAddr = 4'd0; load_done = 1'b0; hash_valid = 1'b0;
        hash_out = '0; loopBusy = 1'b0; badValid = 0; loopTimeouts = 0;
        forever begin
            @(negedge clk);
            if (loopEnable && start === 1'b1 && !rst) serveBlock();
        end
    end

    // s_ready must stay low while a block is in flight or the message tail is being padded
    always @(negedge clk) begin
        if (!rst) begin
            if (start === 1'b1) startCount++;
            if (s_ready === 1'b1 && (loopBusy || start === 1'b1 || (msgDone && digest_valid !== 1'b1)))
                readyViol++;
        end
    end

    task automatic sendBytes(input logic [7:0] msg[$], input int gapMax);
        logic acc;
        int n;
        for (int i = 0; i < msg.size(); i++) begin
            repeat ($urandom_range(0, gapMax)) begin
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 3000) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
                n++;
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (!acc) begin
                checkVal("byteAccept", 512'(acc), 512'(1));
                return;
            end
            if (i == 0) checkVal("digestValidClearOnFirstByte", 512'(digest_valid), 512'(0));
        end
    endtask

    task automatic runMessage(input logic [7:0] msg[$], input string tag, input int gapMax,
                              input int delayMax, output logic [255:0] dig);
        int servedBase, prevBase, startBase, violBase, validBase, toBase, n, idx;
        logic [511:0] got;
        buildRef(msg);
        servedBase = servedWords.size();
        prevBase   = seenPrev.size();
        startBase  = startCount;
        violBase   = readyViol;
        validBase  = badValid;
        toBase     = loopTimeouts;
        hashDelayMax = delayMax;
        loopEnable = 1'b1;
        sendBytes(msg, gapMax);
        msgDone = 1'b1;
        n = 0;
        while (digest_valid !== 1'b1 && n < 8000) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal({tag, " digestValid"}, 512'(digest_valid), 512'(1));
        dig = digest;
        checkVal({tag, " digest"}, 512'(digest), 512'(refDigest));
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkVal({tag, " digestHold"}, 512'(digest_valid), 512'(1));
        msgDone = 1'b0;
        checkVal({tag, " startPulses"}, 512'(startCount - startBase), 512'(refBlocks.size()));
        checkVal({tag, " wordCount"}, 512'(servedWords.size() - servedBase), 512'(16 * refBlocks.size()));
        for (int bi = 0; bi < refBlocks.size(); bi++) begin
            got = 'x;
            if (servedBase + 16*bi + 15 < servedWords.size()) begin
                got = '0;
                for (int w = 0; w < 16; w++) got = {got[479:0], servedWords[servedBase + 16*bi + w]};
            end
            checkVal($sformatf("%s block%0d", tag, bi), got, refBlocks[bi]);
            idx = prevBase + bi;
            got = (idx < seenPrev.size()) ? 512'(seenPrev[idx]) : 'x;
            checkVal($sformatf("%s prevHash%0d", tag, bi), got, 512'(refChain[bi]));
        end
        checkVal({tag, " wordValid"}, 512'(badValid - validBase), 512'(0));
        checkVal({tag, " hashAckTimeout"}, 512'(loopTimeouts - toBase), 512'(0));
        checkVal({tag, " readyLowWhileBusy"}, 512'(readyViol - violBase), 512'(0));
        servedBase = servedBase;
    endtask

    typedef struct {
        logic [447:0] text;
        int           textLen;
        int           repCount;
        logic [7:0]   repByte;
        logic         haveDigest;
        logic [255:0] expDigest;
        int           blkA;
        int           wordA;
        logic [31:0]  valA;
        int           blkB;
        int           wordB;
        logic [31:0]  valB;
        int           gapMax;
        int           delayMax;
    } vec_t;

    vec_t vecs[4];

    task automatic applyStimulus(input vec_t v, input string tag);
        logic [7:0]   msg[$];
        logic [255:0] dig;
        int           base, idx;
        logic [31:0]  got;
        if (v.textLen > 0) begin
            for (int i = 0; i < v.textLen; i++) msg.push_back(v.text[8*(v.textLen - 1 - i) +: 8]);
        end else begin
            for (int i = 0; i < v.repCount; i++) msg.push_back(v.repByte);
        end
        base = servedWords.size();
        runMessage(msg, tag, v.gapMax, v.delayMax, dig);
        if (v.haveDigest) checkVal({tag, " knownDigest"}, 512'(dig), 512'(v.expDigest));
        idx = base + 16 * v.blkA + v.wordA;
        got = (idx < servedWords.size()) ? servedWords[idx] : 'x;
        checkVal($sformatf("%s b%0dw%0d", tag, v.blkA, v.wordA), 512'(got), 512'(v.valA));
        idx = base + 16 * v.blkB + v.wordB;
        got = (idx < servedWords.size()) ? servedWords[idx] : 'x;
        checkVal($sformatf("%s b%0dw%0d", tag, v.blkB, v.wordB), 512'(got), 512'(v.valB));
    endtask

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0]   msg[$];
        logic [255:0] d0, d1;
        int           n;
        int           lens[5];

        vecs[0] = '{448'("abc"), 3, 0, 8'h00, 1'b1,
                    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
                    0, 0, 32'h61626380, 0, 15, 32'h00000018, 0, 0};
        vecs[1] = '{448'("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 56, 0, 8'h00, 1'b1,
                    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
                    1, 15, 32'h000001c0, 0, 14, 32'h80000000, 3, 5};
        vecs[2] = '{448'(0), 0, 55, 8'h61, 1'b0, 256'h0,
                    0, 13, 32'h61616180, 0, 15, 32'h000001b8, 0, 20};
        vecs[3] = '{448'(0), 0, 64, 8'h61, 1'b0, 256'h0,
                    1, 0, 32'h80000000, 1, 15, 32'h00000200, 2, 2};

        rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        mReq = 1'b1; mAddr = 4'd3;
        #12;
        checkVal("resetEnable", 512'(enable), 512'(0));
        checkVal("resetDigest", 512'(digest), 512'(0));
        checkVal("resetDigestValid", 512'(digest_valid), 512'(0));
        checkVal("resetPrevHash", 512'(prev_hash), 512'(IV));
        checkVal("resetStart", 512'(start), 512'(0));
        checkVal("resetWordValid", 512'(word_valid), 512'(0));
        checkVal("resetWordData", 512'(word_data), 512'(0));
        checkVal("resetHashAck", 512'(hash_ack), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkVal("postResetReady", 512'(s_ready), 512'(1));
        checkVal("postResetEnable", 512'(enable), 512'(1));
        mReq = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of serving a block, then the same message again
        loopEnable = 1'b0;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        sendBytes(msg, 0);
        n = 0;
        while (start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("midResetStartSeen", 512'(start), 512'(1));
        @(posedge clk); #1;
        mAddr = 4'd0; mReq = 1'b1;
        #1;
        checkVal("midResetServeWord0", 512'(word_data), 512'(32'h61626380));
        rst = 1'b1;
        #1;
        checkVal("midResetEnable", 512'(enable), 512'(0));
        checkVal("midResetWordValid", 512'(word_valid), 512'(0));
        checkVal("midResetWordData", 512'(word_data), 512'(0));
        checkVal("midResetPrevHash", 512'(prev_hash), 512'(IV));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkVal("midResetReady", 512'(s_ready), 512'(1));
        checkVal("midResetNoStaleWord", 512'(word_valid), 512'(0));
        mReq = 1'b0;
        @(posedge clk); #1;
        runMessage(msg, "abcAfterReset", 0, 3, d0);
        checkVal("abcAfterReset known", 512'(d0),
                 512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        // Random messages: gap-free run vs gapped run with slow loop
        lens[0] = 1; lens[1] = 62; lens[2] = 63;
        lens[3] = $urandom_range(2, 140); lens[4] = $urandom_range(2, 140);
        for (int r = 0; r < 5; r++) begin
            msg.delete();
            for (int i = 0; i < lens[r]; i++) msg.push_back(8'($urandom));
            runMessage(msg, $sformatf("rnd%0d_fast", r), 0, 0, d0);
            runMessage(msg, $sformatf("rnd%0d_slow", r), 4, 20, d1);
            checkVal($sformatf("rnd%0d gapInvariant", r), 512'(d1), 512'(d0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
